// File: rtl/muldiv_pkg.sv
// muldiv_pkg: op codes, FSM states and helpers shared by the HI/LO multiply/divide unit.
package muldiv_pkg;

    typedef enum logic [3:0] {
        OP_NOP   = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MFHI  = 4'd5,
        OP_MFLO  = 4'd6,
        OP_MTHI  = 4'd7,
        OP_MTLO  = 4'd8
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_e;

    function automatic logic is_hilo_op(input logic [3:0] o);
        return o >= OP_MULT && o <= OP_MTLO;
    endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// muldiv_sign_fix: operand magnitude capture and result sign correction for the HI/LO unit.
module muldiv_sign_fix #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sgn,
    output logic [WIDTH-1:0] mag_a,
    output logic [WIDTH-1:0] mag_b,
    output logic             neg_a,
    output logic             neg_b,
    input  logic [WIDTH-1:0] res_hi,
    input  logic [WIDTH-1:0] res_lo,
    input  logic             mul,
    input  logic             neg_lo,
    input  logic             neg_hi,
    output logic [WIDTH-1:0] fix_hi,
    output logic [WIDTH-1:0] fix_lo
);
    logic [2*WIDTH-1:0] prod, prod_n;

    assign neg_a  = sgn && a[WIDTH-1];
    assign neg_b  = sgn && b[WIDTH-1];
    assign mag_a  = neg_a ? -a : a;
    assign mag_b  = neg_b ? -b : b;
    // A product is negated as one double-width value so the borrow crosses into HI.
    assign prod   = {res_hi, res_lo};
    assign prod_n = neg_lo ? -prod : prod;
    assign fix_hi = mul ? prod_n[2*WIDTH-1:WIDTH] : neg_hi ? -res_hi : res_hi;
    assign fix_lo = mul ? prod_n[WIDTH-1:0] : neg_lo ? -res_lo : res_lo;

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative radix-2 MULT/MULTU/DIV/DIVU engine owning HI/LO, with MFHI/MFLO/MTHI/MTLO.
// Divide path present only when MULDIV_DIV_EN is defined; otherwise DIV/DIVU are illegal ops.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             op_valid,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    output logic             stall,
    output logic [WIDTH-1:0] rd_data,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic             illegal_op
);
    state_e           state, state_d;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] hi, lo, acc_hi, acc_lo, opb;
    logic [WIDTH-1:0] mag_a, mag_b, fix_hi, fix_lo, step_hi, step_lo;
    logic             mul_q, neg_lo_q, neg_hi_q, neg_a, neg_b;
    logic             is_mul, is_div, div_by_zero, accept, legal;
    logic [WIDTH:0]   mul_sum;

    assign is_mul = op == OP_MULT || op == OP_MULTU;
`ifdef MULDIV_DIV_EN
    assign is_div = op == OP_DIV || op == OP_DIVU;
`else
    assign is_div = 1'b0;
`endif
    assign div_by_zero = is_div && rt_val == '0;
    assign legal   = op == OP_NOP || is_mul || is_div || (is_hilo_op(op) && op >= OP_MFHI);
    assign busy    = state != IDLE;
    assign stall   = op_valid && busy && op != OP_NOP;
    assign accept  = op_valid && !stall;
    assign rd_data = !op_valid ? '0 : op == OP_MFHI ? hi : op == OP_MFLO ? lo : '0;

    muldiv_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
        .a      (rs_val),
        .b      (rt_val),
        .sgn    (op == OP_MULT || op == OP_DIV),
        .mag_a  (mag_a),
        .mag_b  (mag_b),
        .neg_a  (neg_a),
        .neg_b  (neg_b),
        .res_hi (acc_hi),
        .res_lo (acc_lo),
        .mul    (mul_q),
        .neg_lo (neg_lo_q),
        .neg_hi (neg_hi_q),
        .fix_hi (fix_hi),
        .fix_lo (fix_lo)
    );

    // acc_hi:acc_lo holds product-upper:multiplier while multiplying, remainder:quotient while dividing.
    assign mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : '0);

`ifdef MULDIV_DIV_EN
    logic [WIDTH:0]   div_shift;
    logic [WIDTH-1:0] div_diff;
    logic             div_ge;

    assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
    assign div_ge    = div_shift >= {1'b0, opb};
    assign div_diff  = div_shift[WIDTH-1:0] - opb;

    always_comb begin
        step_hi = mul_q ? mul_sum[WIDTH:1] : div_ge ? div_diff : div_shift[WIDTH-1:0];
        step_lo = mul_q ? {mul_sum[0], acc_lo[WIDTH-1:1]} : {acc_lo[WIDTH-2:0], div_ge};
    end

    logic dz_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            dz_q     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            if (state == IDLE && accept) dz_q <= div_by_zero;
            div_zero <= state == FIX && dz_q;
        end
    end
`else
    assign step_hi  = mul_sum[WIDTH:1];
    assign step_lo  = {mul_sum[0], acc_lo[WIDTH-1:1]};
    assign div_zero = 1'b0;
`endif

    always_comb begin
        state_d = state;
        if (state == IDLE)
            state_d = !accept ? IDLE : div_by_zero ? FIX : (is_mul || is_div) ? RUN : IDLE;
        else if (state == RUN)
            state_d = cnt == CNT_W'(1) ? FIX : RUN;
        else
            state_d = IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            hi         <= '0;
            lo         <= '0;
            acc_hi     <= '0;
            acc_lo     <= '0;
            opb        <= '0;
            mul_q      <= 1'b0;
            neg_lo_q   <= 1'b0;
            neg_hi_q   <= 1'b0;
            done       <= 1'b0;
            illegal_op <= 1'b0;
        end else begin
            state      <= state_d;
            done       <= state == FIX;
            illegal_op <= accept && !legal;
            if (state == IDLE && accept && (is_mul || is_div)) begin
                cnt      <= CNT_W'(WIDTH);
                mul_q    <= is_mul;
                opb      <= mag_b;
                acc_hi   <= div_by_zero ? rs_val : '0;
                acc_lo   <= div_by_zero ? '1 : mag_a;
                neg_lo_q <= !div_by_zero && (neg_a ^ neg_b);
                neg_hi_q <= !div_by_zero && (is_mul ? neg_a ^ neg_b : neg_a);
            end
            if (accept && op == OP_MTHI) hi <= rs_val;
            if (accept && op == OP_MTLO) lo <= rs_val;
            if (state == RUN) begin
                cnt    <= cnt - 1'b1;
                acc_hi <= step_hi;
                acc_lo <= step_lo;
            end
            if (state == FIX) begin
                hi <= fix_hi;
                lo <= fix_lo;
            end
        end
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Parametrised, multi-cycle HI/LO arithmetic unit.
- Executes MULT/MULTU/DIV/DIVU with an iterative radix-2 engine and owns the HI/LO registers.
- Serves MFHI/MFLO/MTHI/MTLO and raises a pipeline stall while a result is pending.
- Sits beside the 32-bit ALU, driven by decoded op codes from the control unit; replaces the single start_mult/mfhi_sel/mflo_sel wiring.

Parameters:
- WIDTH, 32, operand width; HI and LO are WIDTH bits each; must be >= 4.
- CNT_W, $clog2(WIDTH+1), iteration counter width; derived, not overridden.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- op_valid  input  1  op presented this cycle.
- op  input  4  op code from shared package: NOP=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MFHI=5, MFLO=6, MTHI=7, MTLO=8; others illegal.
- rs_val  input  WIDTH  operand A / dividend / MTHI-MTLO source.
- rt_val  input  WIDTH  operand B / divisor.
- stall  output  1  combinational; hold the current op, it is not accepted.
- rd_data  output  WIDTH  combinational HI (MFHI) or LO (MFLO); 0 for other ops.
- busy  output  1  engine running.
- done  output  1  one-cycle pulse after HI/LO are written by MULT/DIV.
- div_zero  output  1  one-cycle pulse, coincident with done, for a DIV/DIVU with rt_val==0.
- illegal_op  output  1  one-cycle registered pulse for an accepted undefined op code.

Behaviour:
- Reset: state=IDLE, HI=LO=0, counter=0; busy=done=div_zero=illegal_op=0.
- Reset mid-operation aborts the operation; HI/LO are not updated by it.
- Acceptance: op is accepted when op_valid && !stall. stall = op_valid && busy && op!=NOP.
- Every HI/LO op, including MFHI/MFLO, stalls while busy. A stalled op is re-evaluated each cycle and is accepted in the cycle after done rises.
- FSM states:
  - IDLE: accept MULT/MULTU/DIV/DIVU -> RUN; capture operand magnitudes (two's-complement abs for signed ops) plus result-sign flags; counter=WIDTH.
  - RUN: one bit per cycle.
    - Multiply: shift-add into a 2*WIDTH product.
    - Divide: restoring shift-subtract.
    - Counter decrements; at 1 -> FIX.
  - FIX: apply signs.
    - Product negated if the operand signs differ.
    - Quotient negated if the signs differ; remainder takes the dividend's sign.
    - Write HI=upper/remainder, LO=lower/quotient; -> IDLE.
- Latency: busy is high for WIDTH+1 cycles, starting the cycle after acceptance. done is high in the first IDLE cycle after FIX.
- Divide by zero: no iteration (RUN skipped, IDLE->FIX); HI=rs_val, LO=all ones; busy=1 for 1 cycle; div_zero pulses with done.
- Signed overflow: DIV of most-negative by -1 gives LO=most-negative, HI=0; no flag.
- MTHI/MTLO: write HI/LO at the accepting edge; visible to an MFHI/MFLO in the next cycle.
- MFHI/MFLO: rd_data is combinational from the current HI/LO; no state change.
- Same-cycle conflict: none possible, because only one op per cycle is accepted.
- Illegal op: no state change; illegal_op pulses the next cycle.

Optional Feature:
- MULDIV_DIV_EN
- Defined: divide path and div_zero are implemented as above.
- Undefined: DIV/DIVU are treated as illegal ops (illegal_op pulse, no busy, HI/LO unchanged); div_zero is tied 0; the divide datapath is absent.

Decomposition:
- Shared package muldiv_pkg:
  - 4-bit op enum and its op code constants.
  - FSM state enum (IDLE, RUN, FIX).
  - is_hilo_op() helper.
- One sub-module: muldiv_sign_fix, the combinational magnitude/negate logic used in IDLE capture and FIX.

Test Plan:
- MULT rs=-3 (0xFFFFFFFD), rt=7 -> done exactly 34 cycles after acceptance; HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001; busy high 33 cycles.
- DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 100/0 -> 2-cycle latency; div_zero=1, LO=0xFFFFFFFF, HI=100.
- MFLO issued 1 cycle after MULT acceptance -> stall=1 for 33 cycles, then accepted; rd_data equals the new LO.
- Reset asserted during RUN of a MULT, after MTLO 0x55 -> HI=LO=0, busy=0 the next cycle, no done.
- Build without MULDIV_DIV_EN: DIV issued -> illegal_op pulse, busy=0, HI/LO unchanged; op 0xF behaves the same with the macro defined.
